// File: rtl/frogger_game_controller.sv
// Frogger game sequencer: game state, lives, level, score,
// frog respawn pulse, global freeze and car speed programming.
module frogger_game_controller #(
    parameter int          c_LIVES_INI      = 3,
    parameter logic [23:0] c_BASE_CAR_SPEED = 24'd1000000,
    parameter logic [23:0] c_SPEED_STEP     = 24'd100000,
    parameter logic [23:0] c_MIN_CAR_SPEED  = 24'd200000,
    parameter logic [7:0]  c_HIT_FRAMES     = 8'd60,
    parameter logic [7:0]  c_GOAL_FRAMES    = 8'd30,
    parameter logic [6:0]  c_SCORE_MAX      = 7'd99
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic        i_Frame_Tick,
    input  logic        i_Start,
    input  logic        i_Has_Collided,
    input  logic        i_Frog_At_Goal,
    output logic [2:0]  o_State,
    output logic        o_Freeze,
    output logic        o_Frog_Reset,
    output logic [23:0] o_Car_Speed,
    output logic [1:0]  o_Lives,
    output logic [3:0]  o_Level,
    output logic [6:0]  o_Score,
    output logic        o_Game_Over
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PLAYING   = 3'd1,
        HIT       = 3'd2,
        GOAL      = 3'd3,
        GAME_OVER = 3'd4
    } state_t;

    localparam logic [1:0] LIVES_INI = 2'(c_LIVES_INI);

    // A zero frame count still freezes for one tick.
    localparam logic [7:0] HIT_LOAD =
        (c_HIT_FRAMES == 8'd0) ? 8'd1 : c_HIT_FRAMES;
    localparam logic [7:0] GOAL_LOAD =
        (c_GOAL_FRAMES == 8'd0) ? 8'd1 : c_GOAL_FRAMES;

    // 25-bit threshold so min + step cannot overflow.
    localparam logic [24:0] SPEED_THRESH =
        {1'b0, c_MIN_CAR_SPEED} + {1'b0, c_SPEED_STEP};

    state_t      state_q, state_d;
    logic        freeze_q, freeze_d;
    logic        frog_reset_q, frog_reset_d;
    logic [23:0] speed_q, speed_d;
    logic [1:0]  lives_q, lives_d;
    logic [3:0]  level_q, level_d;
    logic [6:0]  score_q, score_d;
    logic        game_over_q, game_over_d;
    logic [7:0]  timer_q, timer_d;
    logic        start_q, start_d;
    logic        start_rise;

    assign start_rise = i_Start & ~start_q;

    // Next-state, counters and registered output values.
    always_comb begin
        state_d      = state_q;
        speed_d      = speed_q;
        lives_d      = lives_q;
        level_d      = level_q;
        score_d      = score_q;
        timer_d      = timer_q;
        frog_reset_d = 1'b0;
        start_d      = i_Start;

        unique case (state_q)
            IDLE: begin
                if (start_rise) begin
                    state_d      = PLAYING;
                    lives_d      = LIVES_INI;
                    score_d      = 7'd0;
                    level_d      = 4'd0;
                    speed_d      = c_BASE_CAR_SPEED;
                    frog_reset_d = 1'b1;
                end
            end
            PLAYING: begin
                if (i_Has_Collided) begin
                    state_d = HIT;
                    timer_d = HIT_LOAD;
                    lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
                end else if (i_Frog_At_Goal) begin
                    state_d = GOAL;
                    timer_d = GOAL_LOAD;
                    score_d = (score_q >= c_SCORE_MAX) ?
                              c_SCORE_MAX : score_q + 7'd1;
                    level_d = (level_q == 4'd15) ?
                              4'd15 : level_q + 4'd1;
                    speed_d = ({1'b0, speed_q} >= SPEED_THRESH) ?
                              speed_q - c_SPEED_STEP : c_MIN_CAR_SPEED;
                end
            end
            HIT: begin
                if (i_Frame_Tick) begin
                    if (timer_q <= 8'd1) begin
                        timer_d = 8'd0;
                        if (lives_q == 2'd0) begin
                            state_d = GAME_OVER;
                        end else begin
                            state_d      = PLAYING;
                            frog_reset_d = 1'b1;
                        end
                    end else begin
                        timer_d = timer_q - 8'd1;
                    end
                end
            end
            GOAL: begin
                if (i_Frame_Tick) begin
                    if (timer_q <= 8'd1) begin
                        timer_d      = 8'd0;
                        state_d      = PLAYING;
                        frog_reset_d = 1'b1;
                    end else begin
                        timer_d = timer_q - 8'd1;
                    end
                end
            end
            GAME_OVER: begin
                if (start_rise) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        freeze_d    = (state_d != PLAYING);
        game_over_d = (state_d == GAME_OVER);
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q      <= IDLE;
            freeze_q     <= 1'b1;
            frog_reset_q <= 1'b0;
            speed_q      <= c_BASE_CAR_SPEED;
            lives_q      <= LIVES_INI;
            level_q      <= 4'd0;
            score_q      <= 7'd0;
            game_over_q  <= 1'b0;
            timer_q      <= 8'd0;
            start_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            freeze_q     <= freeze_d;
            frog_reset_q <= frog_reset_d;
            speed_q      <= speed_d;
            lives_q      <= lives_d;
            level_q      <= level_d;
            score_q      <= score_d;
            game_over_q  <= game_over_d;
            timer_q      <= timer_d;
            start_q      <= start_d;
        end
    end

    assign o_State      = state_q;
    assign o_Freeze     = freeze_q;
    assign o_Frog_Reset = frog_reset_q;
    assign o_Car_Speed  = speed_q;
    assign o_Lives      = lives_q;
    assign o_Level      = level_q;
    assign o_Score      = score_q;
    assign o_Game_Over  = game_over_q;

endmodule

// File: tb/tb_frogger_game_controller.sv
// Bench for frogger_game_controller: scoreboard of expected
// output snapshots, popped and compared per scenario.
module tb_frogger_game_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick = 1'b0;
    logic        start = 1'b0;
    logic        coll = 1'b0;
    logic        goal = 1'b0;
    logic [2:0]  st;
    logic        fz;
    logic        fr;
    logic [23:0] sp;
    logic [1:0]  lv;
    logic [3:0]  lvl;
    logic [6:0]  sc;
    logic        go;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0]  st;
        logic        fz;
        logic        fr;
        logic [23:0] sp;
        logic [1:0]  lv;
        logic [3:0]  lvl;
        logic [6:0]  sc;
        logic        go;
    } obs_t;

    obs_t  exp_q[$];
    obs_t  got_q[$];
    string nm_q[$];

    frogger_game_controller #(
        .c_LIVES_INI      (3),
        .c_BASE_CAR_SPEED (24'd1000),
        .c_SPEED_STEP     (24'd300),
        .c_MIN_CAR_SPEED  (24'd400),
        .c_HIT_FRAMES     (8'd3),
        .c_GOAL_FRAMES    (8'd2),
        .c_SCORE_MAX      (7'd99)
    ) dut (
        .i_Clk          (clk),
        .i_Reset        (rst),
        .i_Frame_Tick   (tick),
        .i_Start        (start),
        .i_Has_Collided (coll),
        .i_Frog_At_Goal (goal),
        .o_State        (st),
        .o_Freeze       (fz),
        .o_Frog_Reset   (fr),
        .o_Car_Speed    (sp),
        .o_Lives        (lv),
        .o_Level        (lvl),
        .o_Score        (sc),
        .o_Game_Over    (go)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(
        input logic [2:0] s, input logic f, input logic r,
        input logic [23:0] p, input logic [1:0] l,
        input logic [3:0] v, input logic [6:0] c, input logic g);
        obs_t o;
        o.st = s; o.fz = f; o.fr = r; o.sp = p;
        o.lv = l; o.lvl = v; o.sc = c; o.go = g;
        return o;
    endfunction

    // Push expectation, clock once, then record what the DUT shows.
    task automatic step(input string nm, input obs_t e);
        obs_t g;
        nm_q.push_back(nm);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        g = mk(st, fz, fr, sp, lv, lvl, sc, go);
        got_q.push_back(g);
    endtask

    task automatic frame(input string nm, input obs_t e);
        tick = 1'b1;
        step(nm, e);
        tick = 1'b0;
    endtask

    task automatic test_reset;
        obs_t e, g;
        string n;
        rst = 1'b1;
        step("reset", mk(0, 1, 0, 1000, 3, 0, 0, 0));
        rst = 1'b0;
        step("idle_hold", mk(0, 1, 0, 1000, 3, 0, 0, 0));
        frame("idle_tick", mk(0, 1, 0, 1000, 3, 0, 0, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n = nm_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL %s: got %h required %h", n, g, e);
            end
        end
    endtask

    task automatic test_start;
        obs_t e, g;
        string n;
        start = 1'b1;
        step("start_edge", mk(1, 0, 1, 1000, 3, 0, 0, 0));
        step("start_held", mk(1, 0, 0, 1000, 3, 0, 0, 0));
        start = 1'b0;
        frame("play_tick", mk(1, 0, 0, 1000, 3, 0, 0, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n = nm_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL %s: got %h required %h", n, g, e);
            end
        end
    endtask

    task automatic test_hit;
        obs_t e, g;
        string n;
        coll = 1'b1;
        step("hit_enter", mk(2, 1, 0, 1000, 2, 0, 0, 0));
        step("hit_no_tick", mk(2, 1, 0, 1000, 2, 0, 0, 0));
        frame("hit_t1", mk(2, 1, 0, 1000, 2, 0, 0, 0));
        frame("hit_t2", mk(2, 1, 0, 1000, 2, 0, 0, 0));
        coll = 1'b0;
        frame("hit_expire", mk(1, 0, 1, 1000, 2, 0, 0, 0));
        step("hit_fr_drop", mk(1, 0, 0, 1000, 2, 0, 0, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n = nm_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL %s: got %h required %h", n, g, e);
            end
        end
    endtask

    task automatic test_goals;
        obs_t e, g;
        string n;
        logic [23:0] spd [3];
        spd[0] = 24'd700; spd[1] = 24'd400; spd[2] = 24'd400;
        for (int k = 0; k < 3; k++) begin
            goal = 1'b1;
            step($sformatf("goal%0d_enter", k),
                 mk(3, 1, 0, spd[k], 2, 4'(k + 1), 7'(k + 1), 0));
            goal = 1'b0;
            frame($sformatf("goal%0d_t1", k),
                  mk(3, 1, 0, spd[k], 2, 4'(k + 1), 7'(k + 1), 0));
            frame($sformatf("goal%0d_expire", k),
                  mk(1, 0, 1, spd[k], 2, 4'(k + 1), 7'(k + 1), 0));
            step($sformatf("goal%0d_play", k),
                 mk(1, 0, 0, spd[k], 2, 4'(k + 1), 7'(k + 1), 0));
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n = nm_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL %s: got %h required %h", n, g, e);
            end
        end
    endtask

    task automatic test_both;
        obs_t e, g;
        string n;
        coll = 1'b1;
        goal = 1'b1;
        step("both_hit_wins", mk(2, 1, 0, 400, 1, 3, 3, 0));
        coll = 1'b0;
        goal = 1'b0;
        frame("both_t1", mk(2, 1, 0, 400, 1, 3, 3, 0));
        frame("both_t2", mk(2, 1, 0, 400, 1, 3, 3, 0));
        frame("both_expire", mk(1, 0, 1, 400, 1, 3, 3, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n = nm_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL %s: got %h required %h", n, g, e);
            end
        end
    endtask

    task automatic test_game_over;
        obs_t e, g;
        string n;
        coll = 1'b1;
        start = 1'b1;
        step("last_hit", mk(2, 1, 0, 400, 0, 3, 3, 0));
        coll = 1'b0;
        frame("last_t1", mk(2, 1, 0, 400, 0, 3, 3, 0));
        frame("last_t2", mk(2, 1, 0, 400, 0, 3, 3, 0));
        frame("game_over", mk(4, 1, 0, 400, 0, 3, 3, 1));
        step("go_start_held", mk(4, 1, 0, 400, 0, 3, 3, 1));
        start = 1'b0;
        step("go_released", mk(4, 1, 0, 400, 0, 3, 3, 1));
        start = 1'b1;
        step("go_to_idle", mk(0, 1, 0, 400, 0, 3, 3, 0));
        start = 1'b0;
        step("idle_wait", mk(0, 1, 0, 400, 0, 3, 3, 0));
        start = 1'b1;
        step("new_game", mk(1, 0, 1, 1000, 3, 0, 0, 0));
        start = 1'b0;
        step("new_game_run", mk(1, 0, 0, 1000, 3, 0, 0, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n = nm_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL %s: got %h required %h", n, g, e);
            end
        end
    endtask

    task automatic test_reset_mid;
        obs_t e, g;
        string n;
        goal = 1'b1;
        step("mid_goal", mk(3, 1, 0, 700, 3, 1, 1, 0));
        goal = 1'b0;
        frame("mid_goal_exp", mk(3, 1, 0, 700, 3, 1, 1, 0));
        frame("mid_goal_back", mk(1, 0, 1, 700, 3, 1, 1, 0));
        coll = 1'b1;
        step("mid_hit", mk(2, 1, 0, 700, 2, 1, 1, 0));
        coll = 1'b0;
        frame("mid_hit_t1", mk(2, 1, 0, 700, 2, 1, 1, 0));
        rst = 1'b1;
        tick = 1'b1;
        step("mid_reset", mk(0, 1, 0, 1000, 3, 0, 0, 0));
        tick = 1'b0;
        step("mid_reset_hold", mk(0, 1, 0, 1000, 3, 0, 0, 0));
        rst = 1'b0;
        step("after_reset", mk(0, 1, 0, 1000, 3, 0, 0, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n = nm_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL %s: got %h required %h", n, g, e);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_start();
        test_hit();
        test_goals();
        test_both();
        test_game_over();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
